redirect_ctrl: RTL and testbench
================================

REDIRECT_CTRL -- requirements
Module: redirect_ctrl

Interface
REQ-001 Parameter: XLEN, 64, width of all PC/target buses.
REQ-002 Parameter: CNT_W, 32, width of the performance counters.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ex_valid  input  1  EX stage presents a resolved control-flow result this cycle.
REQ-006 ex_pc  input  XLEN  PC of the resolved instruction.
REQ-007 ex_pc_b_j  input  1  branch/jump unit reports a taken redirect (taken branch, jal, jalr, ecall, mret).
REQ-008 ex_dnpc  input  XLEN  target computed by the branch/jump unit.
REQ-009 ex_pred_npc  input  XLEN  next PC the fetch stage predicted for this instruction.
REQ-010 ex_ready  output  1  controller accepts an EX result this cycle.
REQ-011 trap_valid  input  1  later-stage trap or exception redirect request; highest priority.
REQ-012 trap_pc  input  XLEN  trap target.
REQ-013 redir_valid  output  1  redirect request to fetch.
REQ-014 redir_pc  output  XLEN  redirect target.
REQ-015 redir_ready  input  1  fetch accepts the redirect.
REQ-016 flush_if_id  output  1  one-cycle flush of the IF/ID register.
REQ-017 flush_id_ex  output  1  one-cycle flush of the ID/EX register.
REQ-018 stall_fetch  output  1  fetch holds while a redirect is pending.
REQ-019 cnt_resolved  output  CNT_W  count of accepted EX results.
REQ-020 cnt_mispred  output  CNT_W  count of accepted mispredictions.

Function
REQ-021 actual_npc SHALL be ex_dnpc when ex_pc_b_j=1, else ex_pc+4 computed modulo 2^XLEN.
REQ-022 A mispredict SHALL be an accepted EX result (ex_valid & ex_ready & ~trap_valid) with actual_npc != ex_pred_npc.
REQ-023 The FSM SHALL have exactly two states, IDLE and REDIR; ex_ready=1 only in IDLE, and ex_ready is combinational from state only.
REQ-024 IDLE, mispredict: next state REDIR; redir_pc <= actual_npc; flush_if_id and flush_id_ex high for exactly the first cycle in REDIR.
REQ-025 IDLE, trap_valid=1: next state REDIR; redir_pc <= trap_pc; flushes high for one cycle; a simultaneous ex_valid is discarded and not counted.
REQ-026 REDIR: redir_valid=1 and stall_fetch=1; redir_pc SHALL remain stable until the handshake unless a trap overrides it.
REQ-027 REDIR, redir_valid & redir_ready & ~trap_valid: next state IDLE; handshake may complete in the first REDIR cycle.
REQ-028 REDIR, trap_valid=1: redir_pc <= trap_pc; flushes re-pulse for one cycle; remain in REDIR regardless of redir_ready that cycle.
REQ-029 Correct prediction in IDLE: no redirect, no flush, state unchanged.
REQ-030 cnt_resolved SHALL increment by 1 per accepted EX result; cnt_mispred SHALL increment by 1 per mispredict; both wrap at 2^CNT_W.
REQ-031 Trap redirects SHALL NOT increment either counter.
REQ-032 All outputs except ex_ready SHALL be registered.

Reset
REQ-033 While rst_n=0: state IDLE, redir_valid=0, redir_pc=0, flushes=0, stall_fetch=0, counters=0; ex_ready=1.
REQ-034 Reset asserted mid-REDIR SHALL drop redir_valid immediately, asynchronously; the pending redirect is lost.
REQ-035 The first edge after rst_n rises SHALL behave as IDLE.

Verification
REQ-036 Correct prediction: ex_valid=1, ex_pc=0x80000000, ex_pc_b_j=0, pred=0x80000004 -> no flush, cnt_resolved=1, cnt_mispred=0.
REQ-037 Taken-branch mispredict: ex_pc_b_j=1, dnpc=0x80000100, pred=0x80000004, redir_ready=0 for 3 cycles -> redir_valid held 4 cycles at 0x80000100, flushes 1 cycle, ex_ready=0 until handshake, cnt_mispred=1.
REQ-038 Trap during REDIR: pending 0x80000100, trap_pc=0x80000800 -> redir_pc becomes 0x80000800, flushes re-pulse, counters unchanged.
REQ-039 Simultaneous trap and ex mispredict in IDLE: trap_pc=0x80000800 -> redir_pc=0x80000800, cnt_resolved unchanged.
REQ-040 Wrap: ex_pc=0xFFFFFFFFFFFFFFFC, pc_b_j=0, pred=0 -> no mispredict; cnt_mispred preset to 2^CNT_W-1 plus one mispredict -> 0.
REQ-041 rst_n low in REDIR -> redir_valid=0 immediately, all counters 0.

Source files
------------

// File: rtl/redirect_ctrl_if.sv
// -----------------------------------------------------------------------------
// redirect_ctrl_if
//   Bundle between the pipeline (EX stage, trap logic, fetch) and the redirect
//   controller.
//
//   master : pipeline side. Drives the EX result, the trap request and the
//            fetch-side redir_ready. Observes the controller outputs.
//   slave  : controller side (redirect_ctrl).
//
//   Signals
//     ex_valid, ex_pc, ex_pc_b_j, ex_dnpc, ex_pred_npc  resolved EX result
//     ex_ready                                         controller accepts EX
//     trap_valid, trap_pc                              late-stage trap redirect
//     redir_valid, redir_pc, redir_ready               redirect handshake to fetch
//     flush_if_id, flush_id_ex                         one-cycle pipeline flushes
//     stall_fetch                                      fetch hold while pending
//     cnt_resolved, cnt_mispred                        performance counters
// -----------------------------------------------------------------------------
interface redirect_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);

  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_pc_b_j;
  logic [XLEN-1:0]  ex_dnpc;
  logic [XLEN-1:0]  ex_pred_npc;
  logic             ex_ready;

  logic             trap_valid;
  logic [XLEN-1:0]  trap_pc;

  logic             redir_valid;
  logic [XLEN-1:0]  redir_pc;
  logic             redir_ready;

  logic             flush_if_id;
  logic             flush_id_ex;
  logic             stall_fetch;

  logic [CNT_W-1:0] cnt_resolved;
  logic [CNT_W-1:0] cnt_mispred;

  modport master (
    output ex_valid, ex_pc, ex_pc_b_j, ex_dnpc, ex_pred_npc,
    output trap_valid, trap_pc,
    output redir_ready,
    input  ex_ready,
    input  redir_valid, redir_pc,
    input  flush_if_id, flush_id_ex, stall_fetch,
    input  cnt_resolved, cnt_mispred
  );

  modport slave (
    input  ex_valid, ex_pc, ex_pc_b_j, ex_dnpc, ex_pred_npc,
    input  trap_valid, trap_pc,
    input  redir_ready,
    output ex_ready,
    output redir_valid, redir_pc,
    output flush_if_id, flush_id_ex, stall_fetch,
    output cnt_resolved, cnt_mispred
  );

endinterface

// File: rtl/redirect_ctrl.sv
// -----------------------------------------------------------------------------
// redirect_ctrl
//   Compares the next PC actually produced by a resolved control-flow
//   instruction against the PC fetch predicted for it. On a mismatch, or on a
//   trap request from a later stage, it raises a redirect towards fetch, pulses
//   the IF/ID and ID/EX flushes for one cycle and stalls fetch until fetch
//   accepts the redirect. Traps always win, including over a redirect that is
//   already pending. Two counters track accepted EX results and mispredicts.
//
//   Ports
//     clk    : sole clock, rising edge
//     rst_n  : asynchronous, active-low reset
//     bus    : redirect_ctrl_if slave modport (see interface header)
//
//   All outputs are registered except ex_ready, which is decoded from the
//   state alone so the EX stage never sees a path from its own inputs.
// -----------------------------------------------------------------------------
module redirect_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  redirect_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_t;

  state_t           state;

  logic             redir_valid_q;
  logic [XLEN-1:0]  redir_pc_q;
  logic             flush_q;
  logic             stall_q;
  logic [CNT_W-1:0] cnt_resolved_q;
  logic [CNT_W-1:0] cnt_mispred_q;

  logic             ex_ready_c;
  logic             accept;
  logic             mispredict;
  logic [XLEN-1:0]  seq_npc;
  logic [XLEN-1:0]  actual_npc;

  // The EX result is only consumed while no redirect is outstanding.
  assign ex_ready_c = (state == IDLE);

  // Fall-through PC wraps naturally at the top of the address space.
  assign seq_npc    = bus.ex_pc + XLEN'(4);
  assign actual_npc = bus.ex_pc_b_j ? bus.ex_dnpc : seq_npc;

  // A trap in the same cycle discards the EX result entirely.
  assign accept     = bus.ex_valid & ex_ready_c & ~bus.trap_valid;
  assign mispredict = accept & (actual_npc != bus.ex_pred_npc);

  // Single-process FSM. Flushes default low every cycle and are set only on
  // the edge that loads a new redirect target, which makes them one-cycle
  // pulses aligned with the first cycle the new target is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      redir_valid_q  <= 1'b0;
      redir_pc_q     <= '0;
      flush_q        <= 1'b0;
      stall_q        <= 1'b0;
      cnt_resolved_q <= '0;
      cnt_mispred_q  <= '0;
    end else begin
      flush_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.trap_valid) begin
            state         <= REDIR;
            redir_valid_q <= 1'b1;
            stall_q       <= 1'b1;
            redir_pc_q    <= bus.trap_pc;
            flush_q       <= 1'b1;
          end else if (accept) begin
            cnt_resolved_q <= cnt_resolved_q + CNT_W'(1);
            if (mispredict) begin
              cnt_mispred_q <= cnt_mispred_q + CNT_W'(1);
              state         <= REDIR;
              redir_valid_q <= 1'b1;
              stall_q       <= 1'b1;
              redir_pc_q    <= actual_npc;
              flush_q       <= 1'b1;
            end
          end
        end
        REDIR: begin
          // A trap replaces the pending target and holds the redirect open
          // even if fetch happens to accept in the same cycle.
          if (bus.trap_valid) begin
            redir_pc_q <= bus.trap_pc;
            flush_q    <= 1'b1;
          end else if (bus.redir_ready) begin
            state         <= IDLE;
            redir_valid_q <= 1'b0;
            stall_q       <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          redir_valid_q <= 1'b0;
          stall_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ex_ready     = ex_ready_c;
  assign bus.redir_valid  = redir_valid_q;
  assign bus.redir_pc     = redir_pc_q;
  assign bus.flush_if_id  = flush_q;
  assign bus.flush_id_ex  = flush_q;
  assign bus.stall_fetch  = stall_q;
  assign bus.cnt_resolved = cnt_resolved_q;
  assign bus.cnt_mispred  = cnt_mispred_q;

endmodule

// File: tb/tb_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_redirect_ctrl
//   Directed bench for redirect_ctrl. Counters are built 4 bits wide so their
//   wrap-around can be reached with a short run of mispredicts.
// -----------------------------------------------------------------------------
module tb_redirect_ctrl;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  redirect_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus_if ();

  redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one EX result onto the bus.
  task automatic applyStimulus(input logic valid, input logic [63:0] pc,
                               input logic b_j, input logic [63:0] dnpc,
                               input logic [63:0] pred);
    bus_if.ex_valid    = valid;
    bus_if.ex_pc       = pc;
    bus_if.ex_pc_b_j   = b_j;
    bus_if.ex_dnpc     = dnpc;
    bus_if.ex_pred_npc = pred;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Snapshot of the registered redirect outputs plus ex_ready.
  task automatic checkRedirect(input string tag, input logic valid,
                               input logic [63:0] pc, input logic flush,
                               input logic rdy);
    checkOutput({tag, "_valid"}, 64'(bus_if.redir_valid), 64'(valid));
    checkOutput({tag, "_stall"}, 64'(bus_if.stall_fetch), 64'(valid));
    checkOutput({tag, "_pc"}, bus_if.redir_pc, pc);
    checkOutput({tag, "_flush_if_id"}, 64'(bus_if.flush_if_id), 64'(flush));
    checkOutput({tag, "_flush_id_ex"}, 64'(bus_if.flush_id_ex), 64'(flush));
    checkOutput({tag, "_ex_ready"}, 64'(bus_if.ex_ready), 64'(rdy));
  endtask

  task automatic checkCounters(input string tag, input logic [63:0] res,
                               input logic [63:0] mis);
    checkOutput({tag, "_cnt_resolved"}, 64'(bus_if.cnt_resolved), res);
    checkOutput({tag, "_cnt_mispred"}, 64'(bus_if.cnt_mispred), mis);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
    bus_if.trap_valid  = 1'b0;
    bus_if.trap_pc     = 64'h0;
    bus_if.redir_ready = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkRedirect("reset", 1'b0, 64'h0, 1'b0, 1'b1);
    checkCounters("reset", 64'd0, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Correct not-taken prediction.
    applyStimulus(1'b1, 64'h8000_0000, 1'b0, 64'h0, 64'h8000_0004);
    stepCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
    checkRedirect("correct", 1'b0, 64'h0, 1'b0, 1'b1);
    checkCounters("correct", 64'd1, 64'd0);

    // Taken-branch mispredict, fetch refuses for three cycles. A further EX
    // result is held on the bus meanwhile and must be ignored.
    applyStimulus(1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100, 64'h8000_0004);
    stepCycle();
    checkRedirect("br_c1", 1'b1, 64'h8000_0100, 1'b1, 1'b0);
    checkCounters("br_c1", 64'd2, 64'd1);
    stepCycle();
    checkRedirect("br_c2", 1'b1, 64'h8000_0100, 1'b0, 1'b0);
    stepCycle();
    checkRedirect("br_c3", 1'b1, 64'h8000_0100, 1'b0, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
    stepCycle();
    checkRedirect("br_c4", 1'b1, 64'h8000_0100, 1'b0, 1'b0);
    checkCounters("br_c4", 64'd2, 64'd1);
    bus_if.redir_ready = 1'b1;
    stepCycle();
    bus_if.redir_ready = 1'b0;
    checkRedirect("br_done", 1'b0, 64'h8000_0100, 1'b0, 1'b1);
    checkCounters("br_done", 64'd2, 64'd1);

    // Trap overrides a pending redirect, even with fetch ready that cycle.
    applyStimulus(1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100, 64'h8000_0004);
    stepCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
    checkCounters("pend", 64'd3, 64'd2);
    stepCycle();
    checkRedirect("pend_c2", 1'b1, 64'h8000_0100, 1'b0, 1'b0);
    bus_if.trap_valid  = 1'b1;
    bus_if.trap_pc     = 64'h8000_0800;
    bus_if.redir_ready = 1'b1;
    stepCycle();
    bus_if.trap_valid  = 1'b0;
    bus_if.redir_ready = 1'b0;
    checkRedirect("trap_redir", 1'b1, 64'h8000_0800, 1'b1, 1'b0);
    checkCounters("trap_redir", 64'd3, 64'd2);
    stepCycle();
    checkRedirect("trap_redir_c2", 1'b1, 64'h8000_0800, 1'b0, 1'b0);
    bus_if.redir_ready = 1'b1;
    stepCycle();
    bus_if.redir_ready = 1'b0;
    checkRedirect("trap_redir_done", 1'b0, 64'h8000_0800, 1'b0, 1'b1);

    // Trap and mispredict in the same IDLE cycle: trap wins, EX not counted.
    applyStimulus(1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100, 64'h8000_0004);
    bus_if.trap_valid = 1'b1;
    bus_if.trap_pc    = 64'h8000_0800;
    stepCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
    bus_if.trap_valid = 1'b0;
    checkRedirect("trap_idle", 1'b1, 64'h8000_0800, 1'b1, 1'b0);
    checkCounters("trap_idle", 64'd3, 64'd2);
    bus_if.redir_ready = 1'b1;
    stepCycle();
    bus_if.redir_ready = 1'b0;
    checkRedirect("trap_idle_done", 1'b0, 64'h8000_0800, 1'b0, 1'b1);

    // Fall-through at the top of the address space wraps to zero.
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 64'h0);
    stepCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
    checkRedirect("pc_wrap", 1'b0, 64'h8000_0800, 1'b0, 1'b1);
    checkCounters("pc_wrap", 64'd4, 64'd2);

    // Thirteen mispredicts, each accepted by fetch in its first REDIR cycle.
    bus_if.redir_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100, 64'h8000_0004);
      stepCycle();
      applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
      stepCycle();
    end
    bus_if.redir_ready = 1'b0;
    checkRedirect("burst_done", 1'b0, 64'h8000_0100, 1'b0, 1'b1);
    checkCounters("burst_done", 64'd1, 64'd15);

    // Not-taken mispredict redirects to pc+4 and wraps cnt_mispred to zero.
    applyStimulus(1'b1, 64'h8000_0020, 1'b0, 64'h8000_0100, 64'h8000_0100);
    stepCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
    checkRedirect("nt_mis", 1'b1, 64'h8000_0024, 1'b1, 1'b0);
    checkCounters("nt_mis", 64'd2, 64'd0);

    // Reset asserted mid-REDIR clears everything without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    checkRedirect("rst_redir", 1'b0, 64'h0, 1'b0, 1'b1);
    checkCounters("rst_redir", 64'd0, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset behaves as IDLE.
    applyStimulus(1'b1, 64'h8000_0000, 1'b0, 64'h0, 64'h8000_0004);
    stepCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
    checkRedirect("post_rst", 1'b0, 64'h0, 1'b0, 1'b1);
    checkCounters("post_rst", 64'd1, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
